// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first.
// The rx pin goes through a 2-flop synchroniser, and each bit is sampled at mid-bit.
// Received bytes are presented on a valid/ready handshake.
// frame_err_o and overrun_o are single-cycle registered pulses.
module uart_rx #(
    parameter int CLK_FREQ = 62_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int HALF     = BAUD_DIV / 2;
    localparam int CTR_W    = $clog2(BAUD_DIV);

    localparam logic [CTR_W-1:0] HALF_LAST = CTR_W'(HALF - 1);
    localparam logic [CTR_W-1:0] BIT_LAST  = CTR_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       rxSync_q;
    logic [CTR_W-1:0] baudCnt_q, baudCnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frameErr_q, frameErr_d;
    logic             overrun_q, overrun_d;
    logic             rxS;

    assign rxS         = rxSync_q[1];
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frameErr_q;
    assign overrun_o   = overrun_q;

    // Synchroniser for the asynchronous rx pin; it resets to the idle-high level.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rxSync_q <= 2'b11;
        end else begin
            rxSync_q <= {rxSync_q[0], rx_i};
        end
    end

    // Registers for the receive state, the bit timing and the output side.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            baudCnt_q  <= '0;
            bitIdx_q   <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baudCnt_q  <= baudCnt_d;
            bitIdx_q   <= bitIdx_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            frameErr_q <= frameErr_d;
            overrun_q  <= overrun_d;
        end
    end

    // Frame sequencing and mid-bit sampling, plus the output hold and accept logic.
    always_comb begin
        state_d    = state_q;
        baudCnt_d  = baudCnt_q + 1'b1;
        bitIdx_d   = bitIdx_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        valid_d    = valid_q;
        frameErr_d = 1'b0;
        overrun_d  = 1'b0;

        // A consumer handshake frees the output register. A delivery in the same cycle may refill it.
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rxS) begin
                    state_d   = S_START;
                    baudCnt_d = '0;
                end
            end
            S_START: begin
                if (baudCnt_q == HALF_LAST) begin
                    baudCnt_d = '0;
                    bitIdx_d  = '0;
                    state_d   = rxS ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (baudCnt_q == BIT_LAST) begin
                    baudCnt_d         = '0;
                    shreg_d[bitIdx_q] = rxS;
                    if (bitIdx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baudCnt_q == BIT_LAST) begin
                    baudCnt_d = '0;
                    if (rxS) begin
                        state_d = S_IDLE;
                        if (!valid_q || ready_i) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frameErr_d = 1'b1;
                        state_d    = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rxS) begin
                    state_d   = S_IDLE;
                    baudCnt_d = '0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                baudCnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with BAUD_DIV=16 and HALF=8.
// Expected bytes are queued when a frame is sent, and a monitor pops them on each handshake.
module tb_uart_rx;

    logic       clk;
    logic       rstn;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;

    int         nChecks = 0;
    int         nFails  = 0;
    int         frameErrCnt = 0;
    int         overrunCnt  = 0;
    logic [7:0] expQ[$];

    uart_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_i       (rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: compares every handshake with the queue and counts error pulses.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (valid_o === 1'b1 && ready_i === 1'b1) begin
                nChecks++;
                if (expQ.size() == 0) begin
                    nFails++;
                    $display("[TB] FAIL beat: unexpected byte %02h with empty scoreboard", data_o);
                end else begin
                    logic [7:0] expByte;
                    expByte = expQ.pop_front();
                    if (data_o !== expByte) begin
                        nFails++;
                        $display("[TB] FAIL beat: data %02h, expected %02h", data_o, expByte);
                    end
                end
            end
            if (frame_err_o === 1'b1) frameErrCnt++;
            if (overrun_o === 1'b1) overrunCnt++;
            if (frame_err_o === 1'b1 && overrun_o === 1'b1) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL pulses: frame_err and overrun both high");
            end
        end
    end

    // Send one 8N1 frame. Call this 1ns after a posedge; it returns 1ns after a posedge.
    task automatic send_byte(input logic [7:0] b, input logic stopBit);
        logic [9:0] bits;
        bits = {stopBit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_i = bits[i];
            repeat (16) @(posedge clk);
            #1;
        end
        rx_i = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rx_i = 1'b1;
        ready_i = 1'b1;
        idle(3);
        @(negedge clk);
        nChecks++;
        if (valid_o !== 1'b0 || data_o !== 8'h00 || frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset: valid=%b data=%02h fe=%b ov=%b, expected 0/00/0/0",
                     valid_o, data_o, frame_err_o, overrun_o);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(5);
    endtask

    task automatic test_latency();
        int fe0, ov0;
        fe0 = frameErrCnt;
        ov0 = overrunCnt;
        expQ.push_back(8'hA5);
        fork
            send_byte(8'hA5, 1'b1);
            begin
                repeat (154) @(posedge clk);
                @(negedge clk);
                nChecks++;
                if (valid_o !== 1'b0) begin
                    nFails++;
                    $display("[TB] FAIL latency_early: valid=%b, expected 0", valid_o);
                end
                @(posedge clk);
                @(negedge clk);
                nChecks++;
                if (valid_o !== 1'b1 || data_o !== 8'hA5) begin
                    nFails++;
                    $display("[TB] FAIL latency_edge: valid=%b data=%02h, expected 1/a5", valid_o, data_o);
                end
                @(posedge clk);
                @(negedge clk);
                nChecks++;
                if (valid_o !== 1'b0) begin
                    nFails++;
                    $display("[TB] FAIL single_beat: valid=%b, expected 0", valid_o);
                end
            end
        join
        idle(10);
        nChecks++;
        if (frameErrCnt !== fe0 || overrunCnt !== ov0) begin
            nFails++;
            $display("[TB] FAIL latency_pulses: fe=%0d ov=%0d, expected %0d %0d",
                     frameErrCnt, overrunCnt, fe0, ov0);
        end
    endtask

    task automatic test_back_to_back();
        int fe0, ov0;
        fe0 = frameErrCnt;
        ov0 = overrunCnt;
        expQ.push_back(8'h00);
        expQ.push_back(8'hFF);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(10);
        nChecks++;
        if (expQ.size() !== 0) begin
            nFails++;
            $display("[TB] FAIL back_to_back: %0d bytes still pending, expected 0", expQ.size());
        end
        nChecks++;
        if (frameErrCnt !== fe0 || overrunCnt !== ov0) begin
            nFails++;
            $display("[TB] FAIL b2b_pulses: fe=%0d ov=%0d, expected %0d %0d",
                     frameErrCnt, overrunCnt, fe0, ov0);
        end
    endtask

    task automatic test_false_start();
        int fe0;
        fe0 = frameErrCnt;
        rx_i = 1'b0;
        idle(4);
        rx_i = 1'b1;
        idle(40);
        nChecks++;
        if (valid_o !== 1'b0 || frameErrCnt !== fe0) begin
            nFails++;
            $display("[TB] FAIL false_start: valid=%b fe=%0d, expected 0 %0d", valid_o, frameErrCnt, fe0);
        end
        expQ.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        idle(10);
        nChecks++;
        if (expQ.size() !== 0) begin
            nFails++;
            $display("[TB] FAIL after_glitch: %0d bytes pending, expected 0", expQ.size());
        end
    endtask

    task automatic test_framing();
        int fe0;
        fe0 = frameErrCnt;
        send_byte(8'h55, 1'b0);
        rx_i = 1'b0;
        idle(40);
        rx_i = 1'b1;
        idle(20);
        nChecks++;
        if (frameErrCnt !== fe0 + 1) begin
            nFails++;
            $display("[TB] FAIL frame_err_count: %0d pulses, expected 1", frameErrCnt - fe0);
        end
        expQ.push_back(8'h12);
        send_byte(8'h12, 1'b1);
        idle(10);
        nChecks++;
        if (expQ.size() !== 0 || frameErrCnt !== fe0 + 1) begin
            nFails++;
            $display("[TB] FAIL after_break: pending=%0d fe=%0d, expected 0 1", expQ.size(), frameErrCnt - fe0);
        end
    endtask

    task automatic test_overrun();
        int ov0;
        ov0 = overrunCnt;
        ready_i = 1'b0;
        expQ.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(5);
        @(negedge clk);
        nChecks++;
        if (valid_o !== 1'b1 || data_o !== 8'h11 || overrunCnt !== ov0 + 1) begin
            nFails++;
            $display("[TB] FAIL overrun_hold: valid=%b data=%02h ov=%0d, expected 1/11/1",
                     valid_o, data_o, overrunCnt - ov0);
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        idle(1);
        @(negedge clk);
        nChecks++;
        if (valid_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL overrun_drain: valid=%b, expected 0", valid_o);
        end
        idle(30);
        nChecks++;
        if (valid_o !== 1'b0 || expQ.size() !== 0) begin
            nFails++;
            $display("[TB] FAIL overrun_drop: valid=%b pending=%0d, expected 0 0", valid_o, expQ.size());
        end
    endtask

    task automatic test_accept_on_delivery();
        int ov0;
        ov0 = overrunCnt;
        ready_i = 1'b0;
        expQ.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        idle(3);
        expQ.push_back(8'h77);
        fork
            send_byte(8'h77, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1;
                ready_i = 1'b1;
                @(posedge clk);
                #1;
                ready_i = 1'b0;
            end
        join
        @(negedge clk);
        nChecks++;
        if (valid_o !== 1'b1 || data_o !== 8'h77 || overrunCnt !== ov0) begin
            nFails++;
            $display("[TB] FAIL accept_on_delivery: valid=%b data=%02h ov=%0d, expected 1/77/0",
                     valid_o, data_o, overrunCnt - ov0);
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        idle(3);
        nChecks++;
        if (valid_o !== 1'b0 || expQ.size() !== 0) begin
            nFails++;
            $display("[TB] FAIL delivery_drain: valid=%b pending=%0d, expected 0 0", valid_o, expQ.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int fe0, ov0;
        fe0 = frameErrCnt;
        ov0 = overrunCnt;
        rx_i = 1'b0;
        idle(60);
        rstn = 1'b0;
        rx_i = 1'b1;
        idle(2);
        @(negedge clk);
        nChecks++;
        if (valid_o !== 1'b0 || frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL mid_reset: valid=%b fe=%b ov=%b, expected 0/0/0", valid_o, frame_err_o, overrun_o);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(200);
        nChecks++;
        if (valid_o !== 1'b0 || frameErrCnt !== fe0 || overrunCnt !== ov0) begin
            nFails++;
            $display("[TB] FAIL abort_quiet: valid=%b fe=%0d ov=%0d, expected 0 %0d %0d",
                     valid_o, frameErrCnt, overrunCnt, fe0, ov0);
        end
        expQ.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        idle(10);
        nChecks++;
        if (expQ.size() !== 0) begin
            nFails++;
            $display("[TB] FAIL after_reset: %0d bytes pending, expected 0", expQ.size());
        end
    endtask

    // Runs the scenarios in order, then prints the summary.
    initial begin
        rstn = 1'b0;
        rx_i = 1'b1;
        ready_i = 1'b1;
        #1;
        test_reset();
        test_latency();
        test_back_to_back();
        test_false_start();
        test_framing();
        test_overrun();
        test_accept_on_delivery();
        test_reset_mid_frame();
        idle(5);
        nChecks++;
        if (expQ.size() !== 0) begin
            nFails++;
            $display("[TB] FAIL final_queue: %0d bytes pending, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
